// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and default sizes.
// fetch_entry_t is the {pc, inst} pair carried from fetch to decode.
package cpu_pkg;

  localparam int unsigned CPU_PC_W     = 32;
  localparam int unsigned CPU_INST_W   = 32;
  localparam int unsigned INST_Q_DEPTH = 8;

  typedef struct packed {
    logic [CPU_PC_W-1:0]   pc;
    logic [CPU_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction FIFO.
// Buffers {pc, inst} pairs so fetch can run ahead of decode. full stalls
// fetch, out_ready stalls dispatch, and flush (redirect) empties the queue.
// Optional feature: define INST_QUEUE_BYPASS_EN to forward an incoming entry
// straight to the output when the queue is empty (zero-latency path).
// PC_W / INST_W must match the widths of cpu_pkg::fetch_entry_t.
module inst_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH  = INST_Q_DEPTH,
  parameter int unsigned PC_W   = CPU_PC_W,
  parameter int unsigned INST_W = CPU_INST_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INST_W-1:0]          in_inst,
  input  logic                       flush,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [PC_W-1:0]            out_pc,
  output logic [INST_W-1:0]          out_inst,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  fetch_entry_t    head;
  logic            empty;
  logic            byp;
  logic            byp_consume;
  logic            push;
  logic            pop;
  logic            wr_en;
  logic            rd_adv;

  // Status flags come only from registered occupancy.
  always_comb begin
    empty = (count == '0);
    full  = (count == CW'(DEPTH));
  end

  // Bypass qualifier: empty queue with a live, unflushed incoming entry.
  always_comb begin
`ifdef INST_QUEUE_BYPASS_EN
    byp = empty & in_valid & ~flush;
`else
    byp = 1'b0;
`endif
  end

  // Handshake decode; a bypassed entry taken by decode never touches storage.
  always_comb begin
    push        = in_valid & ~full & ~flush;
    pop         = out_valid & out_ready & ~flush;
    byp_consume = byp & out_ready;
    wr_en       = push & ~byp_consume;
    rd_adv      = pop & ~byp_consume;
  end

  // Head presentation: bypass data, else stored head, zeroed while empty.
  always_comb begin
    head      = mem[rd_ptr];
    out_valid = ~empty | byp;
    if (byp) begin
      out_pc   = in_pc;
      out_inst = in_inst;
    end else if (empty) begin
      out_pc   = '0;
      out_inst = '0;
    end else begin
      out_pc   = head.pc;
      out_inst = head.inst;
    end
  end

  // Storage write; contents need no reset since empty masks the output.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr].pc   <= in_pc;
      mem[wr_ptr].inst <= in_inst;
    end
  end

  // Pointer and occupancy registers; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_adv})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
